// File: rtl/riscv_nn_trace_classifier.sv
// riscv_nn_trace_classifier
//   Programmable classifier for the retired-instruction stream of the nn core.
//   N_CLASSES mask/match slots classify each retired instruction; the lowest
//   enabled matching slot wins. Each class keeps a saturating retire counter,
//   and every hit is queued (pc, instr, class) in a trace FIFO drained by an
//   external sink over valid/ready. The block only observes the core.
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   instr_valid_i/instr_rdata_i/pc_i   retired instruction stream
//   cfg_we_i/cfg_idx_i/cfg_mask_i/cfg_match_i/cfg_en_i   slot programming
//   cnt_clear_i                     clear all class counters and drop counter
//   cnt_o                           counter of class cfg_idx_i
//   drop_cnt_o                      hits lost because the FIFO was full
//   trace_valid_o/trace_ready_i     FIFO head handshake
//   trace_pc_o/trace_instr_o/trace_class_o   FIFO head payload
//   fifo_level_o                    FIFO occupancy
module riscv_nn_trace_classifier #(
  parameter int N_CLASSES  = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          instr_valid_i,
  input  logic [31:0]                   instr_rdata_i,
  input  logic [31:0]                   pc_i,
  input  logic                          cfg_we_i,
  input  logic [$clog2(N_CLASSES)-1:0]  cfg_idx_i,
  input  logic [31:0]                   cfg_mask_i,
  input  logic [31:0]                   cfg_match_i,
  input  logic                          cfg_en_i,
  input  logic                          cnt_clear_i,
  output logic [CNT_WIDTH-1:0]          cnt_o,
  output logic [CNT_WIDTH-1:0]          drop_cnt_o,
  output logic                          trace_valid_o,
  input  logic                          trace_ready_i,
  output logic [31:0]                   trace_pc_o,
  output logic [31:0]                   trace_instr_o,
  output logic [$clog2(N_CLASSES)-1:0]  trace_class_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
  localparam int IW = $clog2(N_CLASSES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [31:0]          mask_q  [N_CLASSES];
  logic [31:0]          mask_d  [N_CLASSES];
  logic [31:0]          match_q [N_CLASSES];
  logic [31:0]          match_d [N_CLASSES];
  logic                 en_q    [N_CLASSES];
  logic                 en_d    [N_CLASSES];
  logic [CNT_WIDTH-1:0] cnt_q   [N_CLASSES];
  logic [CNT_WIDTH-1:0] cnt_d   [N_CLASSES];
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;

  // Payload storage carries no reset; level_q alone decides what is valid.
  logic [31:0]          fifo_pc_mem    [FIFO_DEPTH];
  logic [31:0]          fifo_instr_mem [FIFO_DEPTH];
  logic [IW-1:0]        fifo_class_mem [FIFO_DEPTH];

  logic [N_CLASSES-1:0] slot_hit;
  logic                 hit;
  logic [IW-1:0]        hit_idx;
  logic                 full, pop, push, drop;

  for (genvar gi = 0; gi < N_CLASSES; gi++) begin : g_slot
    assign slot_hit[gi] = en_q[gi] && ((instr_rdata_i & mask_q[gi]) == match_q[gi]);
  end

  // Descending scan so the lowest-index hit is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_CLASSES - 1; k >= 0; k--) begin
      if (instr_valid_i && slot_hit[k]) begin
        hit     = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  assign full = (level_q == LW'(FIFO_DEPTH));
  assign pop  = trace_valid_o && trace_ready_i;
  // A pop frees the slot in the same edge, so a full FIFO can still accept.
  assign push = hit && (!full || pop);
  assign drop = hit && full && !pop;

  always_comb begin
    for (int k = 0; k < N_CLASSES; k++) begin
      mask_d[k]  = mask_q[k];
      match_d[k] = match_q[k];
      en_d[k]    = en_q[k];
      cnt_d[k]   = cnt_q[k];
      if (cfg_we_i && (cfg_idx_i == IW'(k))) begin
        mask_d[k]  = cfg_mask_i;
        match_d[k] = cfg_match_i;
        en_d[k]    = cfg_en_i;
      end
      if (cnt_clear_i)
        cnt_d[k] = '0;
      else if (hit && (hit_idx == IW'(k)) && (cnt_q[k] != CNT_MAX))
        cnt_d[k] = cnt_q[k] + 1'b1;
    end
    drop_d = drop_q;
    if (cnt_clear_i)
      drop_d = '0;
    else if (drop && (drop_q != CNT_MAX))
      drop_d = drop_q + 1'b1;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)
      level_d = level_q + LW'(1);
    else if (pop && !push)
      level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CLASSES; k++) begin
        mask_q[k]  <= '0;
        match_q[k] <= '0;
        en_q[k]    <= 1'b0;
        cnt_q[k]   <= '0;
      end
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      for (int k = 0; k < N_CLASSES; k++) begin
        mask_q[k]  <= mask_d[k];
        match_q[k] <= match_d[k];
        en_q[k]    <= en_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_mem[wr_ptr_q]    <= pc_i;
      fifo_instr_mem[wr_ptr_q] <= instr_rdata_i;
      fifo_class_mem[wr_ptr_q] <= hit_idx;
    end
  end

  assign cnt_o         = cnt_q[cfg_idx_i];
  assign drop_cnt_o    = drop_q;
  assign fifo_level_o  = level_q;
  assign trace_valid_o = (level_q != '0);
  // Payload reads as zero while empty, including straight after reset.
  assign trace_pc_o    = trace_valid_o ? fifo_pc_mem[rd_ptr_q]    : '0;
  assign trace_instr_o = trace_valid_o ? fifo_instr_mem[rd_ptr_q] : '0;
  assign trace_class_o = trace_valid_o ? fifo_class_mem[rd_ptr_q] : '0;
endmodule

// File: tb/tb_riscv_nn_trace_classifier.sv
module tb_riscv_nn_trace_classifier;
  localparam logic [31:0] ADD  = 32'h00B50533;
  localparam logic [31:0] ADDI = 32'h00150513;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic [31:0] pc_i = '0;
  logic        cfg_we_i = 1'b0;
  logic [2:0]  cfg_idx_i = '0;
  logic [31:0] cfg_mask_i = '0;
  logic [31:0] cfg_match_i = '0;
  logic        cfg_en_i = 1'b0;
  logic        cnt_clear_i = 1'b0;
  logic        trace_ready_i = 1'b0;

  logic [31:0] cnt_o, drop_cnt_o, trace_pc_o, trace_instr_o;
  logic        trace_valid_o;
  logic [2:0]  trace_class_o;
  logic [4:0]  fifo_level_o;

  // Narrow instance: 3-bit counters and a 2-deep FIFO make saturation reachable.
  logic [2:0]  a_cnt_o, a_drop_cnt_o, a_trace_class_o;
  logic [31:0] a_trace_pc_o, a_trace_instr_o;
  logic        a_trace_valid_o;
  logic [1:0]  a_fifo_level_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_nn_trace_classifier #(.N_CLASSES(8), .CNT_WIDTH(32), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid_i), .instr_rdata_i(instr_rdata_i),
    .pc_i(pc_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_mask_i(cfg_mask_i),
    .cfg_match_i(cfg_match_i), .cfg_en_i(cfg_en_i), .cnt_clear_i(cnt_clear_i),
    .cnt_o(cnt_o), .drop_cnt_o(drop_cnt_o), .trace_valid_o(trace_valid_o),
    .trace_ready_i(trace_ready_i), .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
    .trace_class_o(trace_class_o), .fifo_level_o(fifo_level_o));

  riscv_nn_trace_classifier #(.N_CLASSES(8), .CNT_WIDTH(3), .FIFO_DEPTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid_i), .instr_rdata_i(instr_rdata_i),
    .pc_i(pc_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_mask_i(cfg_mask_i),
    .cfg_match_i(cfg_match_i), .cfg_en_i(cfg_en_i), .cnt_clear_i(cnt_clear_i),
    .cnt_o(a_cnt_o), .drop_cnt_o(a_drop_cnt_o), .trace_valid_o(a_trace_valid_o),
    .trace_ready_i(trace_ready_i), .trace_pc_o(a_trace_pc_o), .trace_instr_o(a_trace_instr_o),
    .trace_class_o(a_trace_class_o), .fifo_level_o(a_fifo_level_o));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state (reflects the DUT registers between edges).
  typedef struct packed {logic [31:0] pc; logic [31:0] instr; logic [2:0] cls;} entry_t;
  entry_t      sb[$];
  logic [31:0] m_mask [8] = '{default: '0};
  logic [31:0] m_match[8] = '{default: '0};
  logic        m_en   [8] = '{default: 1'b0};
  logic [31:0] m_cnt  [8] = '{default: '0};
  logic [2:0]  m_acnt [8] = '{default: '0};
  logic [31:0] m_drop = '0;
  logic [2:0]  m_adrop = '0;
  int          m_level = 0;
  int          m_alevel = 0;

  always @(negedge clk) begin
    logic   hit;
    logic [2:0] cls;
    entry_t e;
    chk("level", 64'(fifo_level_o), 64'(m_level));
    chk("valid", 64'(trace_valid_o), 64'(m_level != 0));
    chk("drop", 64'(drop_cnt_o), 64'(m_drop));
    chk("cnt", 64'(cnt_o), 64'(m_cnt[cfg_idx_i]));
    chk("aux_level", 64'(a_fifo_level_o), 64'(m_alevel));
    chk("aux_cnt", 64'(a_cnt_o), 64'(m_acnt[cfg_idx_i]));
    chk("aux_drop", 64'(a_drop_cnt_o), 64'(m_adrop));
    if (m_level == 0)
      chk("idle_payload", {trace_pc_o, trace_instr_o}, 64'd0);
    else if (trace_ready_i) begin
      e = sb.pop_front();
      chk("pop_pc", 64'(trace_pc_o), 64'(e.pc));
      chk("pop_instr", 64'(trace_instr_o), 64'(e.instr));
      chk("pop_class", 64'(trace_class_o), 64'(e.cls));
      $display("pop pc=%08h instr=%08h class=%0d", trace_pc_o, trace_instr_o, trace_class_o);
    end
    if (!rst_n) begin
      sb.delete();
      for (int k = 0; k < 8; k++) begin
        m_mask[k] = '0; m_match[k] = '0; m_en[k] = 1'b0; m_cnt[k] = '0; m_acnt[k] = '0;
      end
      m_drop = '0; m_adrop = '0; m_level = 0; m_alevel = 0;
    end else begin
      hit = 1'b0;
      cls = '0;
      for (int k = 7; k >= 0; k--)
        if (instr_valid_i && m_en[k] && ((instr_rdata_i & m_mask[k]) == m_match[k])) begin
          hit = 1'b1;
          cls = 3'(k);
        end
      if (m_level != 0 && trace_ready_i) m_level--;
      if (m_alevel != 0 && trace_ready_i) m_alevel--;
      if (hit) begin
        if (m_level < 16) begin
          sb.push_back('{pc: pc_i, instr: instr_rdata_i, cls: cls});
          m_level++;
        end else if (m_drop != 32'hFFFFFFFF) m_drop++;
        if (m_alevel < 2) m_alevel++;
        else if (m_adrop != 3'd7) m_adrop++;
        if (m_cnt[cls] != 32'hFFFFFFFF) m_cnt[cls]++;
        if (m_acnt[cls] != 3'd7) m_acnt[cls]++;
      end
      if (cnt_clear_i) begin
        for (int k = 0; k < 8; k++) begin m_cnt[k] = '0; m_acnt[k] = '0; end
        m_drop = '0; m_adrop = '0;
      end
      if (cfg_we_i) begin
        m_mask[cfg_idx_i] = cfg_mask_i; m_match[cfg_idx_i] = cfg_match_i; m_en[cfg_idx_i] = cfg_en_i;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [31:0] mask, input logic [31:0] match, input logic en);
    cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_mask_i = mask; cfg_match_i = match; cfg_en_i = en;
    tick();
    cfg_we_i = 1'b0; cfg_idx_i = '0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
    instr_valid_i = 1'b1; pc_i = pc; instr_rdata_i = instr;
    tick();
    instr_valid_i = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clear_i = 1'b1;
    tick();
    cnt_clear_i = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_level", 64'(fifo_level_o), 64'd0);
    chk("rst_valid", 64'(trace_valid_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: OP-class slot, one ADD
    cfg(3'd0, 32'h7F, 32'h33, 1'b1);
    retire(32'h100, ADD);
    chk("t1_cnt0", 64'(cnt_o), 64'd1);
    chk("t1_head", {trace_pc_o, trace_instr_o}, {32'h100, ADD});
    chk("t1_class", 64'(trace_class_o), 64'd0);
    trace_ready_i = 1'b1; tick(); trace_ready_i = 1'b0;

    // 2: overlapping slots, lowest index wins
    cfg(3'd0, 32'h7F, 32'h13, 1'b1);
    cfg(3'd1, 32'h707F, 32'h13, 1'b1);
    clear_cnt();
    retire(32'h104, ADDI);
    cfg_idx_i = 3'd0; #1 chk("t2_cnt0", 64'(cnt_o), 64'd1);
    cfg_idx_i = 3'd1; #1 chk("t2_cnt1", 64'(cnt_o), 64'd0);
    chk("t2_class", 64'(trace_class_o), 64'd0);
    cfg_idx_i = 3'd0;
    trace_ready_i = 1'b1; tick(); trace_ready_i = 1'b0;

    // 3: overflow with the sink stalled
    clear_cnt();
    for (int i = 0; i < 20; i++) retire(32'h200 + 32'(4 * i), ADDI);
    chk("t3_level", 64'(fifo_level_o), 64'd16);
    chk("t3_drop", 64'(drop_cnt_o), 64'd4);
    chk("t3_cnt0", 64'(cnt_o), 64'd20);
    chk("t3_aux_cnt_sat", 64'(a_cnt_o), 64'd7);
    chk("t3_aux_drop_sat", 64'(a_drop_cnt_o), 64'd7);

    // 4: full FIFO, simultaneous pop and push
    trace_ready_i = 1'b1;
    retire(32'h1000, ADDI);
    chk("t4_level", 64'(fifo_level_o), 64'd16);
    chk("t4_drop", 64'(drop_cnt_o), 64'd4);
    chk("t4_cnt0", 64'(cnt_o), 64'd21);
    for (int i = 0; i < 16; i++) tick();
    chk("t4_drained", 64'(fifo_level_o), 64'd0);

    // 5: saturation on the narrow instance, then clear beats a same-cycle hit
    retire(32'h2000, ADDI);
    chk("t5_aux_hold", 64'(a_cnt_o), 64'd7);
    chk("t5_cnt0", 64'(cnt_o), 64'd22);
    cnt_clear_i = 1'b1;
    retire(32'h2004, ADDI);
    cnt_clear_i = 1'b0;
    chk("t5_clr_cnt", 64'(cnt_o), 64'd0);
    chk("t5_clr_aux", 64'(a_cnt_o), 64'd0);
    chk("t5_clr_drop", 64'(drop_cnt_o), 64'd0);
    tick(); tick(); tick();
    trace_ready_i = 1'b0;

    // 6: reset with 5 entries queued
    for (int i = 0; i < 5; i++) retire(32'h3000 + 32'(4 * i), ADDI);
    chk("t6_level5", 64'(fifo_level_o), 64'd5);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t6_valid", 64'(trace_valid_o), 64'd0);
    chk("t6_level", 64'(fifo_level_o), 64'd0);
    for (int k = 0; k < 8; k++) begin
      cfg_idx_i = 3'(k); #1 chk("t6_cnt", 64'(cnt_o), 64'd0);
    end
    cfg_idx_i = 3'd0;
    retire(32'h4000, ADDI);
    chk("t6_slots_off", 64'(fifo_level_o), 64'd0);
    chk("t6_cnt_off", 64'(cnt_o), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
